// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : FWFT byte FIFO behind the uart receiver. One byte is captured
//               per rising edge of rx_enable. Bytes that arrive while the FIFO
//               is full and not being popped set a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk32,
    input  logic                  reset_,
    input  logic                  rx_enable,
    input  logic [7:0]            rxdata,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int                c_DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]              r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic                    r_rx_enable_q;
    logic                    r_overflow;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_accept;
    logic w_drop;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL_COUNT);
    assign w_push   = rx_enable & ~r_rx_enable_q;
    assign w_pop    = rd_en & ~w_empty;
    // A push into a full FIFO is still accepted when a pop frees the slot.
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;

    always_ff @(posedge clk32) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= rxdata;
        end
    end

    always_ff @(posedge clk32) begin
        if (!reset_) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            // Held high so a level already present at reset release is not a push.
            r_rx_enable_q <= 1'b1;
        end else begin
            r_rx_enable_q <= rx_enable;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
            end else if (w_pop && !w_accept) begin
                r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rd_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic       clk32 = 1'b0;
    logic       reset_;
    logic       rx_enable;
    logic [7:0] rxdata;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       clr_overflow;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] model_q[$];
    logic [7:0] exp_b;

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk32        (clk32),
        .reset_       (reset_),
        .rx_enable    (rx_enable),
        .rxdata       (rxdata),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk32 = ~clk32;

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        rxdata    = b;
        rx_enable = 1'b1;
        tick();
        rx_enable = 1'b0;
        tick();
    endtask

    task automatic pop_byte();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_       = 1'b0;
        rx_enable    = 1'b0;
        rxdata       = 8'h00;
        rd_en        = 1'b0;
        clr_overflow = 1'b0;
        tick();
        tick();
        check("reset_count", 32'(count), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'h00);
        reset_ = 1'b1;
        tick();

        // 1: long rx_enable pulse produces a single push
        rxdata    = 8'h41;
        rx_enable = 1'b1;
        tick();
        check("t1_count_after_edge", 32'(count), 32'd1);
        check("t1_rd_data", 32'(rd_data), 32'h41);
        check("t1_empty", 32'(empty), 32'd0);
        tick();
        tick();
        check("t1_single_push", 32'(count), 32'd1);
        rx_enable = 1'b0;
        tick();
        pop_byte();
        check("t1_empty_after_pop", 32'(empty), 32'd1);

        // 2: fill with 0x00..0x0F, drain in order
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check("t2_full", 32'(full), 32'd1);
        check("t2_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("t2_order", 32'(rd_data), 32'(i));
            pop_byte();
        end
        check("t2_empty", 32'(empty), 32'd1);
        check("t2_full_clear", 32'(full), 32'd0);

        // 3: drop on full sets overflow; set beats clear
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        push_byte(8'hAA);
        check("t3_overflow_set", 32'(overflow), 32'd1);
        check("t3_count", 32'(count), 32'd16);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t3_overflow_clr", 32'(overflow), 32'd0);
        rxdata       = 8'hBB;
        rx_enable    = 1'b1;
        clr_overflow = 1'b1;
        tick();
        check("t3_set_wins", 32'(overflow), 32'd1);
        rx_enable    = 1'b0;
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t3_overflow_clr2", 32'(overflow), 32'd0);
        check("t3_head_intact", 32'(rd_data), 32'h10);

        // 4: push and pop together on a full FIFO
        rxdata    = 8'h55;
        rx_enable = 1'b1;
        rd_en     = 1'b1;
        tick();
        rx_enable = 1'b0;
        rd_en     = 1'b0;
        check("t4_count", 32'(count), 32'd16);
        check("t4_full", 32'(full), 32'd1);
        check("t4_overflow", 32'(overflow), 32'd0);
        tick();
        for (int i = 1; i < 16; i++) begin
            check("t4_order", 32'(rd_data), 32'h10 + 32'(i));
            pop_byte();
        end
        check("t4_last", 32'(rd_data), 32'h55);
        pop_byte();
        check("t4_empty", 32'(empty), 32'd1);

        // 5: rd_en held on empty while a byte arrives
        rd_en = 1'b1;
        tick();
        check("t5_no_underflow_idle", 32'(count), 32'd0);
        rxdata    = 8'h33;
        rx_enable = 1'b1;
        tick();
        rx_enable = 1'b0;
        check("t5_count1", 32'(count), 32'd1);
        check("t5_rd_data", 32'(rd_data), 32'h33);
        tick();
        check("t5_count0", 32'(count), 32'd0);
        check("t5_rd_data_empty", 32'(rd_data), 32'h00);
        tick();
        check("t5_no_underflow", 32'(count), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        rd_en = 1'b0;
        tick();

        // 6: traffic across pointer wrap, then reset mid-stream
        for (int i = 0; i < 5; i++) begin
            push_byte(8'h60 + 8'(i));
            model_q.push_back(8'h60 + 8'(i));
        end
        for (int i = 0; i < 10; i++) begin
            push_byte(8'h80 + 8'(i));
            model_q.push_back(8'h80 + 8'(i));
            exp_b = model_q.pop_front();
            check("t6_order", 32'(rd_data), 32'(exp_b));
            pop_byte();
        end
        check("t6_count", 32'(count), 32'd5);
        for (int i = 0; i < 12; i++) push_byte(8'hC0 + 8'(i));
        check("t6_overflow_before_reset", 32'(overflow), 32'd1);
        reset_    = 1'b0;
        rx_enable = 1'b1;
        tick();
        reset_ = 1'b1;
        check("t6_reset_count", 32'(count), 32'd0);
        check("t6_reset_empty", 32'(empty), 32'd1);
        check("t6_reset_overflow", 32'(overflow), 32'd0);
        tick();
        check("t6_no_push_held_high", 32'(count), 32'd0);
        rx_enable = 1'b0;
        tick();
        rxdata    = 8'h77;
        rx_enable = 1'b1;
        tick();
        rx_enable = 1'b0;
        check("t6_push_after_reset", 32'(count), 32'd1);
        check("t6_rd_data_after_reset", 32'(rd_data), 32'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
